// File: rtl/shift_seq_unit.sv
// Multi-cycle shift unit for the ALU shift path: latches an operand and applies
// one 1-bit SLL/SRA stage per cycle, shamt times, using a start/busy/result_ready handshake.
module shift_seq_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               lr_shift,
  output logic [WIDTH-1:0]   result,
  output logic               busy,
  output logic               result_ready
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]         state;
  logic [WIDTH-1:0]   op_reg;
  logic [SHAMT_W-1:0] cnt;
  logic               dir;

  // result_ready defaults low each edge so a completion yields a single-cycle pulse;
  // the completion edge returns to IDLE so a start in the ready cycle is accepted at once.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      op_reg       <= '0;
      cnt          <= '0;
      dir          <= 1'b0;
      result       <= '0;
      result_ready <= 1'b0;
    end else begin
      result_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_reg <= data_in;
            cnt    <= shamt;
            dir    <= lr_shift;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            op_reg <= dir ? {op_reg[WIDTH-1], op_reg[WIDTH-1:1]}
                          : {op_reg[WIDTH-2:0], 1'b0};
            cnt    <= cnt - 1'b1;
          end else begin
            result       <= op_reg;
            result_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == SHIFT);

endmodule
